// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parameterized serial pattern detector.
package seq_detect_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int         DEFAULT_PAT_W = 4;
  localparam logic [3:0] DEFAULT_PAT   = 4'b1010;

  // fill counts 0..PAT_W-1, so clog2(PAT_W) bits are always enough
  function automatic int fill_w(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and a sticky saturation flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  // clear beats a simultaneous increment; sat rises on the edge that reaches MAX
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt != MAX) cnt <= cnt + W'(1);
      if (cnt >= MAX - W'(1)) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with zero-latency Mealy match and optional match counter.
// Counter built only when SEQ_DETECT_CNT_EN is defined; otherwise outputs tie to 0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = PAT_W'(DEFAULT_PAT),
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int            FW       = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W must be in 2..16");
  end

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] window;

  // window is the candidate pattern: stored history with the current bit as LSB
  assign window = {hist, in};
  assign q      = in_valid && !rst && (fill == FILL_MAX) && (window == PAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= window[PAT_W-2:0];
      if (q && (overlap_en == MODE_NONOVL))
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (q),
    .clr (cnt_clr),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
  assign cnt_sat        = 1'b0;
`endif

endmodule
